regfile_mp: RTL and testbench

- Parametrised multi-read-port register file for the MIPS-32 datapath: 1 write port, NUM_READ combinational read ports.
- Adds over the current single-file design: write enable, hardwired zero register, write-to-read bypass, synchronous clear.
- Adds a pending-write scoreboard, so decode can stall on registers whose load/multi-cycle result has not returned.
- Sits between decode (read/reserve) and writeback (write/release).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 68 ++++++
 rtl/regfile_mp.sv | 74 +++++++
 tb/tb_regfile_mp.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the MIPS-32 datapath.
// Decode and writeback stages use the same index and data typedefs.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    typedef logic [DEF_DATA_W-1:0] reg_data_t;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, reserve-over-release
// priority, registered pending count and per-port busy lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rsv_en,
    input  logic [ADDR_W-1:0]          i_rsv_addr,
    input  logic                       i_rel_en,
    input  logic [ADDR_W-1:0]          i_rel_addr,
    input  logic [NUM_READ*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_READ-1:0]        o_busy,
    output logic [ADDR_W:0]            o_count
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [DEPTH-1:0] ONE_HOT = DEPTH'(1);
    localparam logic [ADDR_W:0]  CNT_ONE = (ADDR_W+1)'(1);

    logic [DEPTH-1:0] r_pend;
    logic [ADDR_W:0]  r_count;

    logic             w_rsv_ok;
    logic [DEPTH-1:0] w_rsv_mask;
    logic [DEPTH-1:0] w_rel_mask;
    logic             w_inc;
    logic             w_dec;

    // Reserves of the hardwired zero register never become outstanding.
    assign w_rsv_ok   = i_rsv_en && !((ZERO_REG != 0) && (i_rsv_addr == ADDR_W'(REG_ZERO)));
    assign w_rsv_mask = w_rsv_ok ? (ONE_HOT << i_rsv_addr) : '0;
    assign w_rel_mask = i_rel_en ? (ONE_HOT << i_rel_addr) : '0;

    // Count moves only on real bit transitions, so it tracks popcount exactly.
    assign w_inc = w_rsv_ok && !r_pend[i_rsv_addr];
    assign w_dec = i_rel_en && r_pend[i_rel_addr] && !(w_rsv_ok && (i_rsv_addr == i_rel_addr));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend  <= '0;
            r_count <= '0;
        end else begin
            r_pend <= (r_pend & ~w_rel_mask) | w_rsv_mask;
            if (w_inc && !w_dec) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_inc && w_dec) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_busy
        logic [ADDR_W-1:0] w_ra;
        logic              w_rel_hit;
        assign w_ra      = i_rd_addr[k*ADDR_W +: ADDR_W];
        assign w_rel_hit = (BYPASS != 0) && i_rel_en && (i_rel_addr == w_ra);
        assign o_busy[k] = r_pend[w_ra] && !w_rel_hit;
    end

    assign o_count = r_count;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, hardwired zero register
// and a pending-write scoreboard for decode stalls.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_READ*ADDR_W-1:0] ReadAddr,
    output logic [NUM_READ*DATA_W-1:0] ReadData,
    output logic [NUM_READ-1:0]        ReadBusy,
    input  logic                       WriteEnable,
    input  logic [ADDR_W-1:0]          WriteAddr,
    input  logic [DATA_W-1:0]          WriteData,
    input  logic                       ReserveEnable,
    input  logic [ADDR_W-1:0]          ReserveAddr,
    output logic [ADDR_W:0]            PendingCount,
    output logic                       AnyPending
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_ok;

    assign w_wr_ok = WriteEnable && !((ZERO_REG != 0) && (WriteAddr == ADDR_W'(REG_ZERO)));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[WriteAddr] <= WriteData;
        end
    end

    // Zero-register masking is applied last so it also overrides the bypass.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_W-1:0] w_ra;
        logic              w_fwd;
        logic              w_zero;
        assign w_ra   = ReadAddr[k*ADDR_W +: ADDR_W];
        assign w_fwd  = (BYPASS != 0) && WriteEnable && (WriteAddr == w_ra);
        assign w_zero = (ZERO_REG != 0) && (w_ra == ADDR_W'(REG_ZERO));
        assign ReadData[k*DATA_W +: DATA_W] = w_zero ? '0 :
                                              w_fwd  ? WriteData : r_mem[w_ra];
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_READ (NUM_READ),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .i_clk      (Clock),
        .i_rst      (Reset),
        .i_rsv_en   (ReserveEnable),
        .i_rsv_addr (ReserveAddr),
        .i_rel_en   (WriteEnable),
        .i_rel_addr (WriteAddr),
        .i_rd_addr  (ReadAddr),
        .o_busy     (ReadBusy),
        .o_count    (PendingCount)
    );

    assign AnyPending = (PendingCount != '0);

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: behavioural model feeds an expectation
// queue at drive time; entries are popped and compared when outputs settle.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NR     = 2;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [NR*ADDR_W-1:0] ReadAddr;
    logic [NR*DATA_W-1:0] ReadData;
    logic [NR-1:0]     ReadBusy;
    logic              WriteEnable;
    logic [ADDR_W-1:0] WriteAddr;
    logic [DATA_W-1:0] WriteData;
    logic              ReserveEnable;
    logic [ADDR_W-1:0] ReserveAddr;
    logic [ADDR_W:0]   PendingCount;
    logic              AnyPending;

    regfile_mp dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .ReadAddr     (ReadAddr),
        .ReadData     (ReadData),
        .ReadBusy     (ReadBusy),
        .WriteEnable  (WriteEnable),
        .WriteAddr    (WriteAddr),
        .WriteData    (WriteData),
        .ReserveEnable(ReserveEnable),
        .ReserveAddr  (ReserveAddr),
        .PendingCount (PendingCount),
        .AnyPending   (AnyPending)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       tag;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic [5:0]  cnt;
        logic        any;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem [32];
    logic        m_pend [32];
    int          n_checks = 0;
    int          n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (WriteEnable && WriteAddr == a) return WriteData;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (WriteEnable && WriteAddr == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic logic [5:0] model_count();
        logic [5:0] c = '0;
        for (int i = 0; i < 32; i++) c += {5'd0, m_pend[i]};
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // One clock: drive at negedge, check settled outputs, then advance the model at posedge.
    task automatic cyc(input string tag, input logic rst,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] rsa,
                       input logic [4:0] ra0, input logic [4:0] ra1);
        exp_t e;
        exp_t got;
        Reset         = rst;
        WriteEnable   = we;
        WriteAddr     = wa;
        WriteData     = wd;
        ReserveEnable = re;
        ReserveAddr   = rsa;
        ReadAddr      = {ra1, ra0};
        #1;
        e.tag = tag;
        e.d0  = exp_rd(ra0);
        e.d1  = exp_rd(ra1);
        e.b0  = exp_busy(ra0);
        e.b1  = exp_busy(ra1);
        e.cnt = model_count();
        e.any = (model_count() != 6'd0);
        exp_q.push_back(e);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 64'd0, 64'd1);
        end else begin
            got = exp_q.pop_front();
            check({got.tag, ".d0"},  64'(ReadData[31:0]),  64'(got.d0));
            check({got.tag, ".d1"},  64'(ReadData[63:32]), 64'(got.d1));
            check({got.tag, ".b0"},  64'(ReadBusy[0]),     64'(got.b0));
            check({got.tag, ".b1"},  64'(ReadBusy[1]),     64'(got.b1));
            check({got.tag, ".cnt"}, 64'(PendingCount),    64'(got.cnt));
            check({got.tag, ".any"}, 64'(AnyPending),      64'(got.any));
        end
        @(posedge Clock);
        if (rst) begin
            model_clear();
        end else begin
            if (we && wa != 5'd0) m_mem[wa] = wd;
            if (we) m_pend[wa] = 1'b0;
            if (re && rsa != 5'd0) m_pend[rsa] = 1'b1;
        end
        @(negedge Clock);
    endtask

    initial begin
        Reset = 1'b1; WriteEnable = 1'b0; WriteAddr = '0; WriteData = '0;
        ReserveEnable = 1'b0; ReserveAddr = '0; ReadAddr = '0;
        model_clear();
        repeat (2) @(posedge Clock);
        @(negedge Clock);

        // Reset state across all indices on both ports
        for (int i = 0; i < 32; i++)
            cyc("rst_rd", 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));

        // Bypass of same-cycle write, then held value, then disabled write
        cyc("byp_wr",  0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 6);
        cyc("byp_hold",0, 0, 0, 0,            0, 0, 5, 5);
        cyc("we0",     0, 0, 5, 32'h1234,     0, 0, 5, 0);
        cyc("we0_aft", 0, 0, 0, 0,            0, 0, 5, 5);

        // Zero register ignores write and reserve
        cyc("zero_wr", 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        cyc("zero_aft",0, 0, 0, 0,            0, 0, 0, 5);

        // Reserve r3, r7, then release r3 with bypass
        cyc("rsv3",    0, 0, 0, 0,     1, 3, 3, 7);
        cyc("rsv7",    0, 0, 0, 0,     1, 7, 3, 7);
        cyc("busy",    0, 0, 0, 0,     0, 0, 3, 7);
        cyc("rel3",    0, 1, 3, 32'h55, 0, 0, 3, 7);
        cyc("rel3_aft",0, 0, 0, 0,     0, 0, 3, 7);

        // Reserve beats same-cycle release; net-zero reserve/release
        cyc("rsv9",    0, 0, 0, 0,      1, 9, 9, 7);
        cyc("rsv_rel9",0, 1, 9, 32'h99, 1, 9, 9, 7);
        cyc("aft9",    0, 0, 0, 0,      0, 0, 9, 7);
        cyc("r4_rel7", 0, 1, 7, 32'h77, 1, 4, 4, 7);
        cyc("aft47",   0, 0, 0, 0,      0, 0, 4, 7);

        // Double reserve is idempotent; write to non-pending keeps count
        cyc("rsv4again",0, 0, 0, 0,     1, 4, 4, 9);
        cyc("wr_np",   0, 1, 12, 32'hC, 0, 0, 12, 4);
        cyc("aft_np",  0, 0, 0, 0,      0, 0, 12, 4);

        // Fill every reservable register, then drain
        for (int i = 1; i < 32; i++)
            cyc("fill", 0, 0, 0, 0, 1, 5'(i), 5'(i), 0);
        cyc("full",    0, 0, 0, 0, 1, 31, 31, 1);
        cyc("full2",   0, 0, 0, 0, 0, 0,  1, 30);
        for (int i = 1; i < 32; i++)
            cyc("drain", 0, 1, 5'(i), 32'(i * 3), 0, 0, 5'(i), 5'(32 - i));
        cyc("empty",   0, 0, 0, 0, 0, 0, 2, 3);

        // Random traffic against the model
        for (int n = 0; n < 300; n++)
            cyc("rand", 0, 1'($urandom), 5'($urandom), $urandom,
                1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));

        // Reset dominates a same-cycle write
        cyc("pre2",    0, 0, 0, 0,            1, 2, 2, 8);
        cyc("pre8",    0, 0, 0, 0,            1, 8, 2, 8);
        cyc("pre10",   0, 1, 10, 32'hA5A5A5A5, 0, 0, 10, 2);
        cyc("rst_wr",  1, 1, 11, 32'h1111,    1, 6, 10, 11);
        cyc("post_rst",0, 0, 0, 0,            0, 0, 10, 11);
        cyc("post_rst2",0,0, 0, 0,            0, 0, 2, 8);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
